// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the BCD-to-binary path.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  function automatic int cnt_w(input int digits);
    return $clog2(digits + 1);
  endfunction
endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal accumulate step: acc_next = acc*10 + d, with a flag for a legal digit.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] d,
  output logic [OUT_W-1:0]   acc_next,
  output logic               dig_ok
);
  // x10 as x8 + x2, truncated to OUT_W
  assign acc_next = (acc << 3) + (acc << 1) + OUT_W'(d);
  assign dig_ok   = (d <= DIGIT_W'(BCD_MAX));
endmodule

// File: rtl/bcd_to_binary.sv
// Serial packed-BCD to binary converter, one digit per clock, MSD first.
// Optional signed result via `BCD2BIN_NEG_EN (adds neg_in).
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
`ifdef BCD2BIN_NEG_EN
  input  logic                      neg_in,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [OUT_W-1:0]          result,
  output logic                      err
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = cnt_w(DIGITS);

  state_e           state, state_nxt;
  logic [BW-1:0]    sr;
  logic [OUT_W-1:0] acc, acc_next, res_fin;
  logic [CW-1:0]    cnt;
  logic             err_acc, dig_ok, last, err_fin;
`ifdef BCD2BIN_NEG_EN
  logic             neg_q;
`endif

  bcd_digit_mac #(.OUT_W(OUT_W)) u_mac (
    .acc      (acc),
    .d        (sr[BW-1 -: DIGIT_W]),
    .acc_next (acc_next),
    .dig_ok   (dig_ok)
  );

  assign last    = (cnt == CW'(DIGITS - 1));
  assign err_fin = err_acc | ~dig_ok;

  // Value committed on the final digit; an illegal digit discards the magnitude.
  always_comb begin
    res_fin = acc_next;
`ifdef BCD2BIN_NEG_EN
    if (neg_q) res_fin = -acc_next;
`endif
    if (err_fin) res_fin = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
`ifdef BCD2BIN_NEG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          sr      <= bcd_in;
          acc     <= '0;
          cnt     <= '0;
          err_acc <= 1'b0;
`ifdef BCD2BIN_NEG_EN
          neg_q   <= neg_in;
`endif
        end
        CONV: begin
          acc <= acc_next;
          sr  <= sr << DIGIT_W;
          cnt <= cnt + CW'(1);
          if (!dig_ok) err_acc <= 1'b1;
          if (last) begin
            result <= res_fin;
            err    <= err_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomized scoreboard bench for bcd_to_binary against an arithmetic reference model.
module tb_bcd_to_binary;
  localparam int DIGITS = 8;
  localparam int OUT_W  = 32;
  localparam int BW     = 4 * DIGITS;
`ifdef BCD2BIN_NEG_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  typedef struct {
    logic [OUT_W-1:0] res;
    logic             err;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, start, neg_in;
  logic [BW-1:0]    bcd_in;
  logic             busy, done, err;
  logic [OUT_W-1:0] result;

  exp_t             exp_q[$];
  int               errs = 0, checks = 0, cyc = 0;
  logic [OUT_W-1:0] last_res = '0;
  logic             last_err = 1'b0;

  bcd_to_binary #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
`ifdef BCD2BIN_NEG_EN
    .neg_in (neg_in),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: value = sum of digit * 10^position; any nibble > 9 is an error.
  function automatic exp_t model(input logic [BW-1:0] b, input logic n);
    exp_t             e;
    longint unsigned  mag = 0, p = 1;
    logic [3:0]       dg;
    logic [OUT_W-1:0] m;
    e.err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      dg = b[4*i +: 4];
      if (dg > 4'd9) e.err = 1'b1;
      mag += longint'(dg) * p;
      p *= 10;
    end
    m = mag[OUT_W-1:0];
    e.res = e.err ? '0 : ((n && NEG) ? -m : m);
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_busy", busy, 1);
        chk("result", result, e.res);
        chk("err", err, e.err);
        last_res = e.res;
        last_err = e.err;
      end
    end
  end

  // Issues one accepted start; optionally pokes start/bcd_in while busy to show they are ignored.
  task automatic conv(input logic [BW-1:0] b, input logic n, input bit junk);
    exp_t e;
    @(negedge clk);
    bcd_in = b;
    neg_in = n;
    start  = 1'b1;
    e      = model(b, n);
    e.cyc  = cyc + 1 + DIGITS;
    exp_q.push_back(e);
    for (int i = 0; i < DIGITS; i++) begin
      @(negedge clk);
      start  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bcd_in = BW'($urandom);
      neg_in = 1'($urandom_range(0, 1));
      chk("busy_conv", busy, 1);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_done", busy, 1);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_idle", busy, 0);
      chk("result_held", result, last_res);
      chk("err_held", err, last_err);
    end
  endtask

  function automatic logic [BW-1:0] rand_bcd();
    logic [BW-1:0] b;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return b;
  endfunction

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    neg_in = 1'b0;
    bcd_in = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    conv(32'h0000_1234, 1'b0, 1'b0); gap(2);
    conv(32'h9999_9999, 1'b0, 1'b0); gap(1);
    conv(32'h0000_0000, 1'b0, 1'b0); gap(1);
    conv(32'h0000_A123, 1'b0, 1'b0); gap(1);
    conv(32'h0000_0007, 1'b0, 1'b0);
    conv(32'h0000_0042, 1'b0, 1'b1); gap(1);
    conv(32'h0000_0099, 1'b0, 1'b0); gap(1);

    // Abort a conversion with reset: outputs clear at once and no done follows.
    @(negedge clk);
    bcd_in = 32'h0000_5678;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_res = '0;
    last_err = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(DIGITS + 3);
    conv(32'h0000_5678, 1'b0, 1'b0); gap(1);

    if (NEG) begin
      conv(32'h0000_1234, 1'b1, 1'b0); gap(1);
      conv(32'h0000_0000, 1'b1, 1'b0); gap(1);
      conv(32'h0000_B001, 1'b1, 1'b0); gap(1);
    end

    for (int t = 0; t < 60; t++) begin
      conv(rand_bcd(), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end

    gap(3);
    chk("pending_done", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential converter from packed BCD to unsigned binary. It is the inverse of the calculator's binary-to-BCD path, and sits between the keypad/digit-entry buffer and the ALU operand registers. It consumes one BCD digit per clock, most-significant digit first, and accumulates acc = acc*10 + digit. It signals completion with a one-cycle done pulse and a held result.

Parameters:
DIGITS, 8, number of BCD nibbles in bcd_in (1..9 supported).
OUT_W, 32, width of the binary result; must satisfy 10^DIGITS - 1 < 2^OUT_W.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  reset; asynchronous, active-low.
start  input  1  request conversion; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD; nibble [4*DIGITS-1 -: 4] is the most significant digit.
busy  output  1  high while a conversion is in progress (CONV or DONE).
done  output  1  one-cycle pulse; result and err are valid from this cycle.
result  output  OUT_W  binary value of the last conversion; held until the next done.
err  output  1  last conversion contained a nibble greater than 9; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE; busy, done, err = 0; result = 0; accumulator, digit counter and shift register are cleared. Reset asserted mid-conversion aborts it, and no done is produced.
- States are IDLE, CONV and DONE.
- IDLE: when start=1 at a clock edge:
  - bcd_in is latched into a shift register; acc = 0, cnt = 0, err_acc = 0.
  - Next state is CONV, and busy=1 from that edge.
  - bcd_in changes after the latch edge have no effect.
- CONV: each edge takes the top nibble d of the shift register.
  - acc <= acc*10 + d, implemented as (acc<<3)+(acc<<1)+d, truncated to OUT_W.
  - The shift register shifts left by 4; cnt increments.
  - If d > 9, err_acc is set sticky for this conversion.
  - On the edge processing digit DIGITS-1, next state is DONE, and result/err are loaded in the same edge.
- DONE: lasts one cycle with done=1 and busy=1. The next edge returns to IDLE.
- Latency: exactly DIGITS edges from the start edge to done being visible, and DIGITS+1 edges until the next start can be accepted.
- err=1 at done forces result = 0; the partial accumulation is discarded.
- Start asserted during CONV or DONE is ignored and not queued. Start held high continuously produces back-to-back conversions with one IDLE cycle between them.
- Result and err change only on the done-producing edge or on reset.
- Leading zero digits need no special case; all DIGITS nibbles are always processed (fixed latency).

Optional Feature:
Macro BCD2BIN_NEG_EN.
- Defined: adds input port neg_in (1 bit), latched with bcd_in on the start edge. At done, if neg_in was 1 and err=0, result = two's complement of the magnitude. Negative zero yields 0.
- Undefined: no neg_in port; result is always the unsigned magnitude.

Decomposition:
- Package bcd_pkg holds:
  - DIGIT_W = 4 and BCD_MAX = 9;
  - the state enum (IDLE, CONV, DONE);
  - the digit-count width function clog2(DIGITS+1).
- One sub-module, bcd_digit_mac: combinational acc_next = acc*10 + d with a digit-valid flag (d <= 9). It is reused by any future decimal-entry logic.
- The FSM, counter and registers stay in bcd_to_binary.

Test Plan:
1. bcd_in=0x00001234, start pulse → done exactly 8 edges later; result=1234 (0x000004D2), err=0; busy high for 9 cycles.
2. bcd_in=0x99999999 → result=99999999 (0x05F5E0FF), err=0. Then bcd_in=0x00000000 → result=0.
3. bcd_in=0x0000A123 → done at the same latency with err=1, result=0. A following conversion of 0x00000007 → err=0, result=7.
4. Start with 0x00000042, then pulse start with 0x00000099 at cycle 3 of CONV → exactly one done, result=42. The second request is ignored.
5. Start with 0x00005678, deassert rst_n at cycle 4 of CONV → all outputs 0 immediately; no done after release; a new start converts normally.
6. With BCD2BIN_NEG_EN defined: bcd_in=0x00001234, neg_in=1 → result=0xFFFFFB2E. bcd_in=0, neg_in=1 → result=0.
